fft_rot_addr_gen: RTL and testbench

FFT_ROT_ADDR_GEN -- requirements
Module: fft_rot_addr_gen

---
 rtl/fft_pkg.sv | 12 +
 rtl/fft_rotate_n.sv | 30 +++
 rtl/fft_rot_addr_gen.sv | 116 +++++++++++
 tb/tb_fft_rot_addr_gen.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT address-sequencing types: FSM state encoding and rotation direction.
package fft_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/fft_rotate_n.sv
// Combinational W-bit barrel rotator, left or right by amt positions.
module fft_rotate_n
  import fft_pkg::*;
#(
  parameter int W = 5
) (
  input  logic [W-1:0]         in,
  input  logic [$clog2(W)-1:0] amt,
  input  logic                 dir,
  output logic [W-1:0]         out
);

  logic [2*W-1:0] dbl;
  logic [2*W-1:0] shifted;

  // Shifting a doubled copy turns the rotate into a plain shift plus a window select.
  always_comb begin
    dbl     = {in, in};
    shifted = '0;
    out     = '0;
    if (dir == DIR_RIGHT) begin
      shifted = dbl >> amt;
      out     = shifted[W-1:0];
    end else begin
      shifted = dbl << amt;
      out     = shifted[2*W-1:W];
    end
  end

endmodule

// File: rtl/fft_rot_addr_gen.sv
// FFT stage address sequencer: walks idx over 2^W per stage and presents
// idx rotated by (stage+1) mod W, with a valid/ready handshake.
module fft_rot_addr_gen
  import fft_pkg::*;
#(
  parameter  int W          = 5,
  parameter  int NUM_STAGES = W,
  localparam int SW         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          start,
  input  logic          dir,
  input  logic          abort,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [W-1:0]  addr,
  output logic [SW-1:0] stage,
  output logic [W-1:0]  idx,
  output logic          busy,
  output logic          done
);

  localparam int             AW         = $clog2(W);
  localparam logic [W-1:0]   IDX_MAX    = '1;
  localparam logic [W-1:0]   IDX_ONE    = 1;
  localparam logic [SW-1:0]  STAGE_ONE  = 1;
  localparam logic [SW-1:0]  STAGE_LAST = SW'(NUM_STAGES - 1);

  fsm_state_t    state, state_nxt;
  logic [W-1:0]  idx_nxt;
  logic [SW-1:0] stage_nxt;
  logic          dir_q, dir_nxt;
  logic          done_nxt;
  logic          xfer;
  logic [AW-1:0] rot_amt;
  logic [W-1:0]  addr_nxt;
  int            r_int;

  assign xfer = out_valid & out_ready;
  assign busy = (state == RUN);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    stage_nxt = stage;
    dir_nxt   = dir_q;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt = RUN;
          dir_nxt   = dir;
          idx_nxt   = '0;
          stage_nxt = '0;
        end
      end
      RUN: begin
        if (xfer) begin
          if (idx == IDX_MAX) begin
            idx_nxt = '0;
            if (stage == STAGE_LAST) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end else begin
              stage_nxt = stage + STAGE_ONE;
            end
          end else begin
            idx_nxt = idx + IDX_ONE;
          end
        end
        // Abort still lets a same-cycle transfer advance idx, but never signals done.
        if (abort) begin
          state_nxt = IDLE;
          done_nxt  = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Rotation is computed on the next-state values so the registered addr lines up with idx/stage.
  always_comb begin
    r_int = int'(stage_nxt) + 1;
    if (r_int == W) r_int = 0;
    rot_amt = AW'(r_int);
  end

  fft_rotate_n #(.W(W)) u_rotate (
    .in  (idx_nxt),
    .amt (rot_amt),
    .dir (dir_nxt),
    .out (addr_nxt)
  );

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      done      <= 1'b0;
      addr      <= '0;
      idx       <= '0;
      stage     <= '0;
      dir_q     <= DIR_LEFT;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt == RUN);
      done      <= done_nxt;
      addr      <= addr_nxt;
      idx       <= idx_nxt;
      stage     <= stage_nxt;
      dir_q     <= dir_nxt;
    end
  end

endmodule

// File: tb/tb_fft_rot_addr_gen.sv
// Directed bench for fft_rot_addr_gen: sweeps in both directions, backpressure,
// abort, reset mid-sweep and a single-stage instance.
module tb_fft_rot_addr_gen;

  logic       clk = 1'b0;
  logic       clr_n, start, dir, abort, out_ready;
  logic       out_valid, busy, done;
  logic [4:0] addr, idx;
  logic [2:0] stage;

  logic       start2, out_ready2;
  logic       out_valid2, busy2, done2;
  logic [4:0] addr2, idx2;
  logic [0:0] stage2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fft_rot_addr_gen #(.W(5), .NUM_STAGES(5)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .dir(dir), .abort(abort),
    .out_ready(out_ready), .out_valid(out_valid), .addr(addr), .stage(stage),
    .idx(idx), .busy(busy), .done(done)
  );

  fft_rot_addr_gen #(.W(5), .NUM_STAGES(1)) dut1 (
    .clk(clk), .clr_n(clr_n), .start(start2), .dir(1'b0), .abort(1'b0),
    .out_ready(out_ready2), .out_valid(out_valid2), .addr(addr2), .stage(stage2),
    .idx(idx2), .busy(busy2), .done(done2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [4:0] rot_ref(input logic [4:0] v, input int r, input logic d);
    logic [4:0] o;
    o = '0;
    for (int i = 0; i < 5; i++) begin
      if (!d) o[(i + r) % 5] = v[i];
      else    o[i] = v[(i + r) % 5];
    end
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One sweep on the main instance; checks every presented beat against the model.
  task automatic sweep(input logic d, input bit bp, input int abort_at,
                       input int start_at, input string tag);
    int n, cyc;
    logic [4:0] ei;
    logic [2:0] es;
    logic was_xfer;
    bit aborted;
    n = 0; cyc = 0; ei = '0; es = '0; aborted = 0;
    start = 1'b1; dir = d; abort = 1'b0; out_ready = 1'b1;
    tick();
    start = 1'b0; dir = ~d;
    check({tag, "_first_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    while (n < 160 && cyc < 3000 && !aborted) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      start     = (start_at == n);
      abort     = (abort_at == n);
      check({tag, "_vld"}, 32'(out_valid), 32'd1);
      check({tag, "_beat"}, 32'({stage, idx, addr}),
            32'({es, ei, rot_ref(ei, (int'(es) + 1) % 5, d)}));
      if (d == 1'b0 && es == 3'd0 && ei == 5'd1)
        check({tag, "_addr_i1"}, 32'(addr), 32'b00010);
      if (d == 1'b0 && es == 3'd0 && ei == 5'b10011)
        check({tag, "_addr_i19"}, 32'(addr), 32'b00111);
      if (d == 1'b1 && es == 3'd1 && ei == 5'd1)
        check({tag, "_addr_r2"}, 32'(addr), 32'b01000);
      if (d == 1'b1 && es == 3'd4 && ei == 5'b10110)
        check({tag, "_addr_r0"}, 32'(addr), 32'b10110);
      was_xfer = out_ready;
      tick();
      cyc++;
      if (was_xfer) begin
        n++;
        if (ei == 5'd31) begin
          ei = '0;
          es = es + 3'd1;
        end else begin
          ei = ei + 5'd1;
        end
        if (abort_at == n - 1) aborted = 1;
      end
    end
    start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    check({tag, "_in_budget"}, 32'(cyc < 3000), 32'd1);
    if (aborted) begin
      check({tag, "_abort_vld"}, 32'(out_valid), 32'd0);
      check({tag, "_abort_done"}, 32'(done), 32'd0);
      check({tag, "_abort_busy"}, 32'(busy), 32'd0);
      check({tag, "_abort_idx"}, 32'(idx), 32'(ei));
      tick();
      check({tag, "_abort_nodone"}, 32'(done), 32'd0);
    end else begin
      check({tag, "_count"}, 32'(n), 32'd160);
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_done_vld"}, 32'(out_valid), 32'd0);
      check({tag, "_done_busy"}, 32'(busy), 32'd0);
      tick();
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    int cnt;
    logic [4:0] ei2;
    clr_n = 1'b0; start = 1'b0; dir = 1'b0; abort = 1'b0; out_ready = 1'b0;
    start2 = 1'b0; out_ready2 = 1'b1;
    tick();
    tick();
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_idx", 32'(idx), 32'd0);
    check("rst_stage", 32'(stage), 32'd0);
    clr_n = 1'b1;
    tick();

    sweep(1'b0, 1'b0, -1, 50, "left");
    sweep(1'b1, 1'b0, -1, -1, "right");
    sweep(1'b0, 1'b1, -1, -1, "bp");
    sweep(1'b0, 1'b0, 40, -1, "abort");
    sweep(1'b1, 1'b0, -1, -1, "restart");

    // Abort wins over start in IDLE.
    start = 1'b1; abort = 1'b1; dir = 1'b0;
    tick();
    start = 1'b0; abort = 1'b0;
    check("prio_busy", 32'(busy), 32'd0);
    check("prio_vld", 32'(out_valid), 32'd0);

    // Reset in the middle of a sweep.
    start = 1'b1; dir = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("mid_busy_pre", 32'(busy), 32'd1);
    clr_n = 1'b0;
    tick();
    check("mrst_vld", 32'(out_valid), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_addr", 32'(addr), 32'd0);
    check("mrst_idx", 32'(idx), 32'd0);
    check("mrst_stage", 32'(stage), 32'd0);
    clr_n = 1'b1;
    tick();

    // Single-stage instance: 32 transfers then done.
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    cnt = 0; ei2 = '0;
    for (int c = 0; c < 100; c++) begin
      if (done2) break;
      if (out_valid2) begin
        check("ns1_beat", 32'({stage2, idx2, addr2}), 32'({1'b0, ei2, rot_ref(ei2, 1, 1'b0)}));
        cnt++;
        ei2 = ei2 + 5'd1;
      end
      tick();
    end
    check("ns1_count", 32'(cnt), 32'd32);
    check("ns1_done", 32'(done2), 32'd1);
    check("ns1_vld", 32'(out_valid2), 32'd0);
    tick();
    check("ns1_done_pulse", 32'(done2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
